// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - LED matrix column scanner with double-buffered frame
// Optional MATRIX_SCAN_BLANKING_EN blanks rows on the first cycle of every column slot.
module matrix_column_scanner #(
    parameter int PRESCALE = 50000,
    parameter int ROWS     = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                scan_enable,
    input  logic [3*ROWS-1:0]   load_data,
    input  logic                load_valid,
    output logic                load_ready,
    output logic [2:0]          ring_counter,
    output logic [ROWS-1:0]     rows,
    output logic                frame_done
);

    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

    logic [TW-1:0]     tick_cnt;
    logic [TW-1:0]     tick_next;
    logic [3*ROWS-1:0] active_frame;
    logic [3*ROWS-1:0] active_next;
    logic [3*ROWS-1:0] shadow_frame;
    logic              shadow_full;
    logic              shadow_full_next;
    logic [2:0]        ring_next;
    logic [ROWS-1:0]   rows_next;
    logic              advance;
    logic              wrap;
    logic              accept;

    always_comb begin
        advance          = scan_enable && (tick_cnt == TICK_LAST);
        wrap             = advance && (ring_counter == 3'b001);
        accept           = load_valid && !shadow_full;

        tick_next = tick_cnt;
        if (scan_enable) begin
            tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end

        ring_next = advance ? {ring_counter[0], ring_counter[2:1]} : ring_counter;

        // Swap only at the frame boundary so a column pair never shows mixed frames.
        active_next = (wrap && shadow_full) ? shadow_frame : active_frame;

        shadow_full_next = shadow_full;
        if (accept) begin
            shadow_full_next = 1'b1;
        end else if (wrap) begin
            shadow_full_next = 1'b0;
        end

        // Rows come from the next ring/frame so they land on the same edge as the ring.
        rows_next = '0;
        if (scan_enable) begin
            case (ring_next)
                3'b100:  rows_next = active_next[ROWS-1:0];
                3'b010:  rows_next = active_next[2*ROWS-1:ROWS];
                default: rows_next = active_next[3*ROWS-1:2*ROWS];
            endcase
        end
`ifdef MATRIX_SCAN_BLANKING_EN
        if (tick_next == '0) begin
            rows_next = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt     <= '0;
            ring_counter <= 3'b100;
            active_frame <= '0;
            shadow_frame <= '0;
            shadow_full  <= 1'b0;
            load_ready   <= 1'b1;
            rows         <= '0;
            frame_done   <= 1'b0;
        end else begin
            tick_cnt     <= tick_next;
            ring_counter <= ring_next;
            active_frame <= active_next;
            if (accept) begin
                shadow_frame <= load_data;
            end
            shadow_full  <= shadow_full_next;
            load_ready   <= !shadow_full_next;
            rows         <= rows_next;
            frame_done   <= wrap;
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - directed bench for matrix_column_scanner (PRESCALE=4, ROWS=7)
module tb_matrix_column_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scan_enable = 1'b0;
    logic [20:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [2:0]  ring_counter;
    logic [6:0]  rows;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int pos = 0;

    localparam logic [20:0] F1 = 21'h1FC07F;
    localparam logic [20:0] FA = {7'h04, 7'h02, 7'h01};
    localparam logic [20:0] FB = {7'h40, 7'h20, 7'h10};
    localparam logic [20:0] FC = {7'h55, 7'h2A, 7'h33};

    matrix_column_scanner #(.PRESCALE(4), .ROWS(7)) dut (
        .clock(clock),
        .reset(reset),
        .scan_enable(scan_enable),
        .load_data(load_data),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ring_counter(ring_counter),
        .rows(rows),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // pos = enabled-cycle position within the 12-cycle frame (4 per slot)
    task automatic step();
        @(posedge clock);
        #1;
        if (scan_enable) pos = (pos + 1) % 12;
    endtask

    function automatic logic [2:0] ring_at(int p);
        logic [2:0] r;
        r = 3'b100;
        return r >> (p / 4);
    endfunction

    function automatic logic [6:0] exp_rows(logic [20:0] f, int p);
        logic [6:0] r;
        case (p / 4)
            0:       r = f[6:0];
            1:       r = f[13:7];
            default: r = f[20:14];
        endcase
`ifdef MATRIX_SCAN_BLANKING_EN
        if (p % 4 == 0) r = '0;
`endif
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++; if (ring_counter !== 3'b100) begin miscompares++; $display("FAIL reset_ring: got %b expected 100", ring_counter); end
        vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL reset_rows: got %h expected 00", rows); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        reset = 1'b0;
        pos = 0;
    endtask

    task automatic test_scan();
        scan_enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++; if (ring_counter !== ring_at(pos)) begin miscompares++; $display("FAIL scan_ring pos %0d: got %b expected %b", pos, ring_counter, ring_at(pos)); end
            vectors++; if (frame_done !== (pos == 0)) begin miscompares++; $display("FAIL scan_frame_done pos %0d: got %b expected %b", pos, frame_done, pos == 0); end
            vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL scan_rows pos %0d: got %h expected 00", pos, rows); end
        end
    endtask

    task automatic test_load();
        step();
        step();
        load_data = F1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_fall: got %b expected 0", load_ready); end
        for (int i = 0; i < 12 && pos != 0; i++) begin
            step();
            if (pos != 0) begin
                vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL load_rows_before_swap pos %0d: got %h expected 00", pos, rows); end
            end
        end
        vectors++; if (rows !== exp_rows(F1, 0)) begin miscompares++; $display("FAIL load_rows_at_wrap: got %h expected %h", rows, exp_rows(F1, 0)); end
        vectors++; if (ring_counter !== 3'b100) begin miscompares++; $display("FAIL load_ring_at_wrap: got %b expected 100", ring_counter); end
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL load_frame_done: got %b expected 1", frame_done); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready_rise: got %b expected 1", load_ready); end
        for (int k = 0; k < 12; k++) begin
            step();
            vectors++; if (rows !== exp_rows(F1, pos)) begin miscompares++; $display("FAIL load_rows pos %0d: got %h expected %h", pos, rows, exp_rows(F1, pos)); end
            vectors++; if (ring_counter !== ring_at(pos)) begin miscompares++; $display("FAIL load_ring pos %0d: got %b expected %b", pos, ring_counter, ring_at(pos)); end
        end
    endtask

    task automatic test_back_to_back();
        step();
        step();
        load_data = FA;
        load_valid = 1'b1;
        step();
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_a: got %b expected 0", load_ready); end
        load_data = FB;
        for (int i = 0; i < 12 && pos != 0; i++) begin
            step();
            if (pos != 0) begin
                vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_held_off pos %0d: got %b expected 0", pos, load_ready); end
                vectors++; if (rows !== exp_rows(F1, pos)) begin miscompares++; $display("FAIL b2b_rows_old pos %0d: got %h expected %h", pos, rows, exp_rows(F1, pos)); end
            end
        end
        vectors++; if (rows !== exp_rows(FA, 0)) begin miscompares++; $display("FAIL b2b_rows_a_wrap: got %h expected %h", rows, exp_rows(FA, 0)); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_swap: got %b expected 1", load_ready); end
        step();
        load_valid = 1'b0;
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_b: got %b expected 0", load_ready); end
        for (int i = 0; i < 12 && pos != 0; i++) begin
            vectors++; if (rows !== exp_rows(FA, pos)) begin miscompares++; $display("FAIL b2b_rows_a pos %0d: got %h expected %h", pos, rows, exp_rows(FA, pos)); end
            step();
        end
        for (int k = 0; k < 12; k++) begin
            vectors++; if (rows !== exp_rows(FB, pos)) begin miscompares++; $display("FAIL b2b_rows_b pos %0d: got %h expected %h", pos, rows, exp_rows(FB, pos)); end
            step();
        end
        vectors++; if (rows !== exp_rows(FB, 0)) begin miscompares++; $display("FAIL b2b_rows_b_repeat: got %h expected %h", rows, exp_rows(FB, 0)); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_idle: got %b expected 1", load_ready); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) step();
        scan_enable = 1'b0;
        load_data = FC;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL hold_accept_frozen: got %b expected 0", load_ready); end
        for (int i = 0; i < 9; i++) begin
            step();
            vectors++; if (ring_counter !== 3'b010) begin miscompares++; $display("FAIL hold_ring: got %b expected 010", ring_counter); end
            vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL hold_rows: got %h expected 00", rows); end
            vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL hold_frame_done: got %b expected 0", frame_done); end
        end
        scan_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (ring_counter !== ring_at(pos)) begin miscompares++; $display("FAIL hold_resume_ring pos %0d: got %b expected %b", pos, ring_counter, ring_at(pos)); end
            vectors++; if (rows !== exp_rows(FB, pos)) begin miscompares++; $display("FAIL hold_resume_rows pos %0d: got %h expected %h", pos, rows, exp_rows(FB, pos)); end
        end
    endtask

    task automatic test_reset_mid();
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (ring_counter !== 3'b100) begin miscompares++; $display("FAIL rstmid_ring: got %b expected 100", ring_counter); end
        vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL rstmid_rows: got %h expected 00", rows); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b expected 1", load_ready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        pos = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            vectors++; if (ring_counter !== ring_at(pos)) begin miscompares++; $display("FAIL rstmid_after_ring pos %0d: got %b expected %b", pos, ring_counter, ring_at(pos)); end
            vectors++; if (rows !== 7'h00) begin miscompares++; $display("FAIL rstmid_discarded pos %0d: got %h expected 00", pos, rows); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
